// File: rtl/arb_pkg.sv
// Definitions shared by the round-robin arbiter and its response router:
// index/count width helpers and the default sizing constants.
package arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DefNumIn    = 4;
    localparam int DefDepth    = 4;
    localparam int DefCntWidth = cnt_width(DefDepth);

    typedef logic [idx_width(DefNumIn)-1:0] idx_t;

endpackage

// File: rtl/arb_rsp_router_idx_fifo.sv
// Plain synchronous FIFO of arbiter indices. It has no bypass, a full FIFO
// refuses pushes, an empty FIFO refuses pops, and flush drops both.
module idx_fifo
    import arb_pkg::*;
#(
    parameter  int Depth    = 4,
    parameter  int IdxWidth = 2,
    localparam int CntWidth = cnt_width(Depth),
    localparam int PtrWidth = ptr_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [IdxWidth-1:0] data_i,
    input  logic                pop_i,
    output logic [IdxWidth-1:0] data_o,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [IdxWidth-1:0] mem_q [Depth];
    logic [IdxWidth-1:0] mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                push, pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        push     = push_i & ~full_o & ~flush_i;
        pop      = pop_i & ~empty_o & ~flush_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Wrap by compare so non-power-of-two depths work.
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/arb_rsp_router.sv
// Response-return stage behind the arbitration tree. It tracks the winner
// of every accepted request and steers in-order responses back to it.
module arb_rsp_router
    import arb_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int Depth     = 4,
    parameter int IdxWidth  = idx_width(NumIn),
    parameter int CntWidth  = cnt_width(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 arb_req_i,
    input  logic [IdxWidth-1:0]  arb_idx_i,
    output logic                 arb_gnt_o,
    output logic                 slv_req_o,
    input  logic                 slv_gnt_i,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 rsp_ready_o,
    output logic [NumIn-1:0]     rsp_valid_o,
    output logic [DataWidth-1:0] rsp_data_o,
    input  logic [NumIn-1:0]     rsp_ready_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 err_o
);

    logic                fifo_full, fifo_empty;
    logic [IdxWidth-1:0] fifo_head, head;
    logic                push;
    logic                err_q, err_d;

    // full is registered, so the grant never depends on the response path.
    assign slv_req_o  = arb_req_i & ~fifo_full;
    assign arb_gnt_o  = slv_gnt_i & ~fifo_full;
    assign push       = arb_req_i & slv_gnt_i & ~fifo_full;
    assign rsp_data_o = rsp_data_i;

    idx_fifo #(
        .Depth    (Depth),
        .IdxWidth (IdxWidth)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (arb_idx_i),
        .pop_i   (rsp_valid_i & rsp_ready_o),
        .data_o  (fifo_head),
        .count_o (outstanding_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    if (NumIn == 1) begin : g_single
        assign head = '0;
    end else begin : g_multi
        assign head = fifo_head;
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < NumIn; i++) begin
                if (head == IdxWidth'(i)) begin
                    rsp_valid_o[i] = rsp_valid_i;
                    rsp_ready_o    = rsp_ready_i[i];
                end
            end
        end
    end

    always_comb begin
        err_d = err_q | (rsp_valid_i & fifo_empty);
        if (flush_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_arb_rsp_router.sv
// Randomized and directed stimulus against a queue-based reference model
// of the response router.
module tb_arb_rsp_router;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, arb_req_i, slv_gnt_i, rsp_valid_i;
    logic [1:0]    arb_idx_i;
    logic [DW-1:0] rsp_data_i;
    logic [N-1:0]  rsp_ready_i;
    logic          arb_gnt_o, slv_req_o, rsp_ready_o, err_o;
    logic [N-1:0]  rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic [2:0]    outstanding_o;

    int n_chk  = 0;
    int n_fail = 0;

    int q[$];
    bit m_err = 0;
    bit blocked = 0;

    always #5 clk = ~clk;

    arb_rsp_router #(.NumIn(N), .DataWidth(DW), .Depth(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .arb_req_i    (arb_req_i),
        .arb_idx_i    (arb_idx_i),
        .arb_gnt_o    (arb_gnt_o),
        .slv_req_o    (slv_req_o),
        .slv_gnt_i    (slv_gnt_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .rsp_ready_o  (rsp_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_ready_i  (rsp_ready_i),
        .outstanding_o(outstanding_o),
        .err_o        (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst_i = 0; flush_i = 0; arb_req_i = 0; arb_idx_i = 0; slv_gnt_i = 0;
        rsp_valid_i = 0; rsp_data_i = '0; rsp_ready_i = '0;
    endtask

    // Checks all outputs against the model mid-cycle, then advances the model
    // by what the upcoming edge should do.
    task automatic tick();
        bit full, push, pop, er;
        logic [N-1:0] ev;
        @(negedge clk);
        full = (q.size() == D);
        ev = '0;
        er = 0;
        if (q.size() > 0) begin
            ev[q[0]] = rsp_valid_i;
            er = rsp_ready_i[q[0]];
        end
        check("slv_req", 32'(slv_req_o), 32'(arb_req_i & ~full));
        check("arb_gnt", 32'(arb_gnt_o), 32'(slv_gnt_i & ~full));
        check("rsp_valid", 32'(rsp_valid_o), 32'(ev));
        check("rsp_ready", 32'(rsp_ready_o), 32'(er));
        check("rsp_data", rsp_data_o, rsp_data_i);
        check("outstanding", 32'(outstanding_o), 32'(q.size()));
        check("err", 32'(err_o), 32'(m_err));
        push = arb_req_i & slv_gnt_i & ~full;
        pop  = rsp_valid_i & er;
        blocked = arb_req_i & ~(slv_gnt_i & ~full);
        if (rst_i || flush_i) begin
            q.delete();
            m_err = 0;
        end else begin
            if (rsp_valid_i && q.size() == 0) m_err = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(int'(arb_idx_i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int idx);
        idle(); arb_req_i = 1; slv_gnt_i = 1; arb_idx_i = 2'(idx); tick();
    endtask

    task automatic respond(input logic [N-1:0] rdy);
        idle(); rsp_valid_i = 1; rsp_data_i = $urandom; rsp_ready_i = rdy; tick();
    endtask

    initial begin
        idle();
        rst_i = 1;
        @(posedge clk);
        #1;
        // Reset held: outputs reflect cleared state, slv_req follows arb_req.
        rst_i = 1; arb_req_i = 1; tick();

        // Basic routing
        grant(2); grant(0);
        check("basic_cnt2", 32'(outstanding_o), 32'd2);
        respond('1);
        check("basic_cnt1", 32'(outstanding_o), 32'd1);
        respond('1);
        check("basic_cnt0", 32'(outstanding_o), 32'd0);

        // Full back-pressure, including a pop while full
        for (int i = 0; i < 4; i++) grant(i);
        check("full_cnt", 32'(outstanding_o), 32'd4);
        grant(3);
        idle(); arb_req_i = 1; slv_gnt_i = 1; arb_idx_i = 2'd1;
        rsp_valid_i = 1; rsp_ready_i = '1; tick();
        check("full_pop_cnt", 32'(outstanding_o), 32'd3);
        for (int i = 0; i < 3; i++) respond('1);

        // Simultaneous push/pop at count 2
        grant(3); grant(1);
        idle(); arb_req_i = 1; slv_gnt_i = 1; arb_idx_i = 2'd2;
        rsp_valid_i = 1; rsp_ready_i = 4'b1000; tick();
        check("pp_cnt", 32'(outstanding_o), 32'd2);
        respond('1); respond('1);

        // Head stall
        grant(1);
        for (int i = 0; i < 3; i++) respond(4'b1101);
        respond(4'b0010);
        check("stall_cnt", 32'(outstanding_o), 32'd0);

        // Spurious response, sticky until flush
        respond('1);
        idle(); tick(); tick();
        check("err_sticky", 32'(err_o), 32'd1);
        idle(); flush_i = 1; tick();
        check("err_flushed", 32'(err_o), 32'd0);

        // Reset mid-operation, then traffic across pointer wrap
        grant(0); grant(1); grant(2);
        idle(); rst_i = 1; tick();
        check("rst_cnt", 32'(outstanding_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            grant((i * 3) % 4);
            respond('1);
        end

        // Random traffic
        idle(); tick();
        for (int c = 0; c < 2000; c++) begin
            if (!blocked) begin
                arb_req_i = 1'($urandom_range(0, 1));
                arb_idx_i = 2'($urandom_range(0, 3));
            end
            slv_gnt_i   = 1'($urandom_range(0, 2) != 0);
            rsp_valid_i = 1'($urandom_range(0, 1));
            rsp_data_i  = $urandom;
            rsp_ready_i = 4'($urandom);
            flush_i     = ($urandom_range(0, 59) == 0);
            rst_i       = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
